// File: rtl/param_updown_counter.sv
// Registered up/down counter over 0..MODULUS-1 with clamped parallel load,
// wrap or saturate at the range ends, registered carry/borrow and live terminal count.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             c,
  output logic             tc
);

  localparam int unsigned    TOP   = MODULUS - 1;
  localparam logic [WIDTH:0] TOP_X = TOP[WIDTH:0];
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   inc_x, dec_x;

  // One extra bit: overshooting the top and borrowing below zero both show up there.
  assign inc_x = {1'b0, count_q} + ONE_X;
  assign dec_x = {1'b0, count_q} - ONE_X;

  always_comb begin
    count_d = count_q;
    c_d     = 1'b0;
    if (load) begin
      if ({1'b0, d} > TOP_X) count_d = TOP_X[WIDTH-1:0];
      else                   count_d = d;
    end else if (en) begin
      if (up) begin
        if (inc_x > TOP_X) begin
          c_d     = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = inc_x[WIDTH-1:0];
        end
      end else begin
        if (dec_x[WIDTH]) begin
          c_d     = 1'b1;
          count_d = (SATURATE != 0) ? count_q : TOP_X[WIDTH-1:0];
        end else begin
          count_d = dec_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      c_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      c_q     <= c_d;
    end
  end

  assign count = count_q;
  assign c     = c_q;
  assign tc    = up ? (count_q == TOP_X[WIDTH-1:0]) : (count_q == '0);

endmodule
